// File: rtl/phase_tracker_if.sv
// Bus-phase monitor taps and the record/status outputs of phase_tracker.
// The master drives the monitor inputs and rec_ready. The slave is the tracker itself.
interface phase_tracker_if #(
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       state_in;
    logic             valid_in;
    logic             rec_ready;
    logic             rec_valid;
    logic [CNT_W-1:0] rec_arbi_len;
    logic [CNT_W-1:0] rec_addr_len;
    logic [CNT_W-1:0] rec_data_len;
    logic             rec_sat;
    logic             err_order;
    logic             err_valid;
    logic [15:0]      txn_count;
    logic [7:0]       drop_count;

    modport master (
        output state_in, valid_in, rec_ready,
        input  rec_valid, rec_arbi_len, rec_addr_len, rec_data_len, rec_sat,
        input  err_order, err_valid, txn_count, drop_count
    );

    modport slave (
        input  state_in, valid_in, rec_ready,
        output rec_valid, rec_arbi_len, rec_addr_len, rec_data_len, rec_sat,
        output err_order, err_valid, txn_count, drop_count
    );
endinterface

// File: rtl/phase_tracker.sv
// Measures the length of each bus phase (ARBI/ADDRESS/DATA) per transaction.
// Completed transactions go into a 2-deep record FIFO. Illegal phase orders are flagged.
module phase_tracker #(
    parameter int unsigned CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    phase_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        PhIdle = 2'd0,
        PhArbi = 2'd1,
        PhAddr = 2'd2,
        PhData = 2'd3
    } phase_e;

    typedef enum logic {
        StSync  = 1'b0,
        StTrack = 1'b1
    } mode_e;

    typedef struct packed {
        logic [CNT_W-1:0] arbi;
        logic [CNT_W-1:0] addr;
        logic [CNT_W-1:0] data;
        logic             sat;
    } rec_t;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    mode_e            r_mode;
    phase_e           r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_arbi_len;
    logic [CNT_W-1:0] r_addr_len;
    rec_t             r_fifo [2];
    logic [1:0]       r_fill;
    logic             r_err_order;
    logic             r_err_valid;
    logic [15:0]      r_txn;
    logic [7:0]       r_drop;

    mode_e            w_mode_nxt;
    phase_e           w_state;
    logic             w_new_ph;
    logic             w_legal;
    logic             w_illegal;
    logic             w_txn_start;
    logic             w_latch_arbi;
    logic             w_latch_addr;
    logic             w_push;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sat_nxt;
    rec_t             w_new_rec;
    rec_t             w_fifo_nxt [2];
    logic [1:0]       w_fill_nxt;
    logic             w_rec_valid;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;

    assign w_state  = phase_e'(bus.state_in);
    assign w_new_ph = (w_state != r_prev);

    always_comb begin
        w_legal = 1'b0;
        unique case (r_prev)
            PhIdle: w_legal = (w_state == PhArbi);
            PhArbi: w_legal = (w_state == PhAddr);
            PhAddr: w_legal = (w_state == PhData);
            PhData: w_legal = (w_state == PhIdle);
        endcase
    end

    // Tracker FSM: decides mode and which bookkeeping event this sample triggers.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_illegal    = 1'b0;
        w_txn_start  = 1'b0;
        w_latch_arbi = 1'b0;
        w_latch_addr = 1'b0;
        w_push       = 1'b0;
        unique case (r_mode)
            StSync: begin
                if (w_state == PhIdle) w_mode_nxt = StTrack;
            end
            StTrack: begin
                if (w_new_ph) begin
                    if (w_legal) begin
                        unique case (r_prev)
                            PhIdle: w_txn_start  = 1'b1;
                            PhArbi: w_latch_arbi = 1'b1;
                            PhAddr: w_latch_addr = 1'b1;
                            PhData: w_push       = 1'b1;
                        endcase
                    end else begin
                        w_illegal = 1'b1;
                        if (w_state != PhIdle) w_mode_nxt = StSync;
                    end
                end
            end
        endcase
    end

    // Saturation only counts against a transaction phase actually being tracked.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_sat_nxt = r_sat;
        if (w_new_ph) begin
            w_cnt_nxt = CntOne;
        end else if (r_cnt != CntMax) begin
            w_cnt_nxt = r_cnt + CntOne;
        end else if (r_mode == StTrack && r_prev != PhIdle) begin
            w_sat_nxt = 1'b1;
        end
        if (w_push || w_illegal || w_txn_start) w_sat_nxt = 1'b0;
    end

    assign w_new_rec = '{arbi: r_arbi_len, addr: r_addr_len, data: r_cnt, sat: r_sat};

    assign w_rec_valid = (r_fill != 2'd0);
    assign w_pop       = w_rec_valid && bus.rec_ready;
    assign w_accept    = w_push && (r_fill != 2'd2 || w_pop);
    assign w_drop      = w_push && !w_accept;

    // Shift FIFO: entry 0 is always the head, so a pop frees a slot for a same-edge push.
    always_comb begin
        w_fifo_nxt = r_fifo;
        w_fill_nxt = r_fill;
        if (w_pop) begin
            w_fifo_nxt[0] = r_fifo[1];
            w_fifo_nxt[1] = '0;
            w_fill_nxt    = r_fill - 2'd1;
        end
        if (w_accept) begin
            w_fifo_nxt[w_fill_nxt[0]] = w_new_rec;
            w_fill_nxt                = w_fill_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= StSync;
            r_prev      <= PhIdle;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_arbi_len  <= '0;
            r_addr_len  <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_fill      <= 2'd0;
            r_err_order <= 1'b0;
            r_err_valid <= 1'b0;
            r_txn       <= 16'd0;
            r_drop      <= 8'd0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_prev      <= w_state;
            r_cnt       <= w_cnt_nxt;
            r_sat       <= w_sat_nxt;
            r_fifo      <= w_fifo_nxt;
            r_fill      <= w_fill_nxt;
            r_err_order <= w_illegal;
            r_err_valid <= (bus.valid_in != (w_state == PhData));
            if (w_latch_arbi) r_arbi_len <= r_cnt;
            if (w_latch_addr) r_addr_len <= r_cnt;
            if (w_push) r_txn <= r_txn + 16'd1;
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    assign bus.rec_valid    = w_rec_valid;
    assign bus.rec_arbi_len = w_rec_valid ? r_fifo[0].arbi : '0;
    assign bus.rec_addr_len = w_rec_valid ? r_fifo[0].addr : '0;
    assign bus.rec_data_len = w_rec_valid ? r_fifo[0].data : '0;
    assign bus.rec_sat      = w_rec_valid ? r_fifo[0].sat  : 1'b0;
    assign bus.err_order    = r_err_order;
    assign bus.err_valid    = r_err_valid;
    assign bus.txn_count    = r_txn;
    assign bus.drop_count   = r_drop;

    a_fill_range: assert property (@(posedge clk) disable iff (rst) r_fill != 2'd3);
    a_order_in_track: assert property (@(posedge clk) disable iff (rst)
        w_illegal |-> r_mode == StTrack);

endmodule

// File: tb/tb_phase_tracker.sv
// Directed bench for phase_tracker: a run-length/queue model of the spec rules is compared
// against the DUT every cycle, plus literal expectations at key points.
module tb_phase_tracker;

    localparam int unsigned CW   = 8;
    localparam int          CMAX = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_ready = 1'b0;

    always #5 clk = ~clk;

    phase_tracker_if #(.CNT_W(CW)) bus_if ();

    phase_tracker #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int a;
        int b;
        int d;
        bit sat;
    } mrec_t;

    mrec_t m_q[$];
    int    m_prev, m_run;
    int    m_len[4];
    bit    m_track, m_eo, m_ev;
    int    m_txn, m_drop;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic int clip(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one sampling edge, expressed as runs of equal phase samples.
    task automatic model_step(input int s, input bit v, input bit r, input bit rs);
        bit    push;
        bit    pop;
        mrec_t rec;
        if (rs) begin
            m_track = 0; m_prev = 0; m_run = 0; m_q.delete();
            m_txn = 0; m_drop = 0; m_eo = 0; m_ev = 0;
            return;
        end
        push = 0;
        m_eo = 0;
        m_ev = (v != (s == 3));
        if (!m_track) begin
            if (s == 0) m_track = 1;
        end else if (s != m_prev) begin
            if (s == (m_prev + 1) % 4) begin
                m_len[m_prev] = m_run;
                if (m_prev == 3) begin
                    push = 1;
                    rec.a = clip(m_len[1]);
                    rec.b = clip(m_len[2]);
                    rec.d = clip(m_run);
                    rec.sat = (m_len[1] > CMAX) || (m_len[2] > CMAX) || (m_run > CMAX);
                end
            end else begin
                m_eo = 1;
                if (s != 0) m_track = 0;
            end
        end
        pop = (m_q.size() > 0) && r;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_txn = (m_txn + 1) % 65536;
            if (m_q.size() < 2) m_q.push_back(rec);
            else if (m_drop < 255) m_drop++;
        end
        m_run  = (s != m_prev) ? 1 : m_run + 1;
        m_prev = s;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int  ea, eb, ed;
            bit  es, ev;
            ev = (m_q.size() > 0);
            ea = ev ? m_q[0].a : 0;
            eb = ev ? m_q[0].b : 0;
            ed = ev ? m_q[0].d : 0;
            es = ev ? m_q[0].sat : 1'b0;
            chk("rec_valid", 32'(bus_if.rec_valid), 32'(ev));
            chk("rec_arbi_len", 32'(bus_if.rec_arbi_len), ea);
            chk("rec_addr_len", 32'(bus_if.rec_addr_len), eb);
            chk("rec_data_len", 32'(bus_if.rec_data_len), ed);
            chk("rec_sat", 32'(bus_if.rec_sat), 32'(es));
            chk("err_order", 32'(bus_if.err_order), 32'(m_eo));
            chk("err_valid", 32'(bus_if.err_valid), 32'(m_ev));
            chk("txn_count", 32'(bus_if.txn_count), m_txn);
            chk("drop_count", 32'(bus_if.drop_count), m_drop);
        end
    end

    task automatic step(input int s, input bit v);
        bus_if.state_in  = 2'(s);
        bus_if.valid_in  = v;
        bus_if.rec_ready = tb_ready;
        @(posedge clk);
        model_step(s, v, tb_ready, rst);
        #1;
    endtask

    task automatic phase(input int s, input int n);
        repeat (n) step(s, s == 3);
    endtask

    // IDLE, ARBI a, ADDRESS b, DATA d; the closing IDLE is issued by the caller.
    task automatic txn(input int a, input int b, input int d);
        phase(0, 1);
        phase(1, a);
        phase(2, b);
        phase(3, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0);
        step(0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        bus_if.state_in  = 2'd0;
        bus_if.valid_in  = 1'b0;
        bus_if.rec_ready = 1'b0;

        do_reset();
        chk("reset rec_valid", 32'(bus_if.rec_valid), 0);
        chk("reset txn_count", 32'(bus_if.txn_count), 0);
        chk("reset drop_count", 32'(bus_if.drop_count), 0);

        // Basic transaction
        tb_ready = 1'b1;
        phase(0, 3); phase(1, 10); phase(2, 9); phase(3, 17);
        step(0, 0);
        chk("t1 rec_valid", 32'(bus_if.rec_valid), 1);
        chk("t1 arbi", 32'(bus_if.rec_arbi_len), 10);
        chk("t1 addr", 32'(bus_if.rec_addr_len), 9);
        chk("t1 data", 32'(bus_if.rec_data_len), 17);
        chk("t1 sat", 32'(bus_if.rec_sat), 0);
        chk("t1 txn", 32'(bus_if.txn_count), 1);
        step(0, 0);
        chk("t1 popped", 32'(bus_if.rec_valid), 0);

        // ARBI -> DATA is illegal; recovery through IDLE
        do_reset();
        phase(0, 2); phase(1, 3);
        step(3, 1);
        chk("t2 err_order", 32'(bus_if.err_order), 1);
        step(3, 1);
        chk("t2 err_order off", 32'(bus_if.err_order), 0);
        phase(0, 2);
        txn(4, 5, 6);
        step(0, 0);
        chk("t2 txn", 32'(bus_if.txn_count), 1);
        chk("t2 arbi", 32'(bus_if.rec_arbi_len), 4);
        chk("t2 data", 32'(bus_if.rec_data_len), 6);

        // valid_in asserted during ADDRESS for two samples
        do_reset();
        phase(0, 1); phase(1, 2); phase(2, 2);
        step(2, 1);
        chk("t3 err_valid a", 32'(bus_if.err_valid), 1);
        step(2, 1);
        chk("t3 err_valid b", 32'(bus_if.err_valid), 1);
        step(2, 0);
        chk("t3 err_valid off", 32'(bus_if.err_valid), 0);
        phase(3, 3);
        step(0, 0);
        chk("t3 addr", 32'(bus_if.rec_addr_len), 5);
        chk("t3 data", 32'(bus_if.rec_data_len), 3);

        // Illegal ARBI -> IDLE keeps tracking
        phase(0, 1); phase(1, 2);
        step(0, 0);
        chk("t4 err_order", 32'(bus_if.err_order), 1);
        txn(3, 2, 2);
        step(0, 0);
        chk("t4 arbi", 32'(bus_if.rec_arbi_len), 3);
        chk("t4 txn", 32'(bus_if.txn_count), 2);

        // Full buffer drops the third record
        do_reset();
        tb_ready = 1'b0;
        txn(2, 3, 4); step(0, 0);
        txn(5, 6, 7); step(0, 0);
        txn(8, 9, 10); step(0, 0);
        chk("t5 drop", 32'(bus_if.drop_count), 1);
        chk("t5 txn", 32'(bus_if.txn_count), 3);
        chk("t5 head arbi", 32'(bus_if.rec_arbi_len), 2);
        tb_ready = 1'b1;
        step(0, 0);
        chk("t5 second arbi", 32'(bus_if.rec_arbi_len), 5);
        chk("t5 second data", 32'(bus_if.rec_data_len), 7);
        step(0, 0);
        chk("t5 empty", 32'(bus_if.rec_valid), 0);

        // Push and pop on the same edge while full
        do_reset();
        tb_ready = 1'b0;
        txn(2, 2, 2); step(0, 0);
        txn(3, 3, 3); step(0, 0);
        txn(4, 4, 4);
        tb_ready = 1'b1;
        step(0, 0);
        chk("t6 drop", 32'(bus_if.drop_count), 0);
        chk("t6 head arbi", 32'(bus_if.rec_arbi_len), 3);
        step(0, 0);
        chk("t6 next arbi", 32'(bus_if.rec_arbi_len), 4);

        // Saturating ARBI phase
        do_reset();
        tb_ready = 1'b1;
        phase(0, 1); phase(1, 300); phase(2, 2); phase(3, 2);
        step(0, 0);
        chk("t7 arbi sat", 32'(bus_if.rec_arbi_len), 255);
        chk("t7 sat", 32'(bus_if.rec_sat), 1);
        txn(2, 2, 2);
        step(0, 0);
        chk("t7 next sat", 32'(bus_if.rec_sat), 0);
        chk("t7 next arbi", 32'(bus_if.rec_arbi_len), 2);

        // Reset during DATA with a record buffered
        do_reset();
        tb_ready = 1'b0;
        txn(2, 2, 2); step(0, 0);
        phase(0, 1); phase(1, 2); phase(2, 2); phase(3, 3);
        rst = 1'b1;
        step(3, 1);
        rst = 1'b0;
        chk("t8 rec_valid", 32'(bus_if.rec_valid), 0);
        chk("t8 txn", 32'(bus_if.txn_count), 0);
        chk("t8 drop", 32'(bus_if.drop_count), 0);
        phase(3, 2);
        step(0, 0);
        chk("t8 no record", 32'(bus_if.rec_valid), 0);
        chk("t8 no err_order", 32'(bus_if.err_order), 0);
        txn(2, 3, 4);
        step(0, 0);
        chk("t8 clean rec", 32'(bus_if.rec_valid), 1);
        chk("t8 clean txn", 32'(bus_if.txn_count), 1);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phase_tracker.md
PHASE_TRACKER -- requirements
Module: phase_tracker

Interface
REQ-001 Parameter CNT_W, default 8, width of each phase-length field and of the phase counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 state_in  input  2  bus phase from the upstream monitor: IDLE=0, ARBI=1, ADDRESS=2, DATA=3.
REQ-005 valid_in  input  1  data-valid from the upstream monitor.
REQ-006 rec_ready  input  1  downstream consumer accepts the head record.
REQ-007 rec_valid  output  1  head record available.
REQ-008 rec_arbi_len, rec_addr_len, rec_data_len  output  CNT_W each  head-record phase lengths, in cycles.
REQ-009 rec_sat  output  1  some phase length in the head record saturated.
REQ-010 err_order  output  1  one-cycle pulse on an illegal phase transition.
REQ-011 err_valid  output  1  one-cycle pulse per cycle where valid_in != (state_in==DATA).
REQ-012 txn_count  output  16  completed transactions, wraps at 16'hFFFF->0.
REQ-013 drop_count  output  8  records lost to a full buffer, saturating at 255.

Function
REQ-014 The block SHALL sample state_in and valid_in on every posedge clk and register prev_state (reset IDLE).
REQ-015 The tracker FSM SHALL have two modes: SYNC and TRACK. Reset enters SYNC. Sampling IDLE in SYNC moves to TRACK on that edge.
REQ-016 In TRACK, legal transitions SHALL be: hold in the same state; IDLE->ARBI; ARBI->ADDRESS; ADDRESS->DATA; DATA->IDLE.
REQ-017 Any other transition in TRACK SHALL do all of: pulse err_order for one cycle; discard the partial transaction; enter SYNC, or stay in TRACK if the new state is IDLE.
REQ-018 In SYNC, no transition SHALL raise err_order.
REQ-019 Phase counter behaviour:
  - loads 1 on the edge that samples a new state;
  - otherwise increments;
  - saturates at 2^CNT_W-1 and sets a sticky sat flag for the current transaction.
REQ-020 Length latching:
  - on ARBI->ADDRESS, latch the counter into arbi_len;
  - on ADDRESS->DATA, into addr_len;
  - on DATA->IDLE, into data_len.
  Each latched value is the count of samples spent in that phase.
REQ-021 On a legal DATA->IDLE transition, the block SHALL push {arbi_len, addr_len, data_len, sat} into a 2-entry FIFO on that same edge, increment txn_count, and clear sat. rec_valid rises on the following cycle.
REQ-022 rec_valid SHALL equal FIFO non-empty. Pop occurs when rec_valid && rec_ready. Outputs present the oldest entry.
REQ-023 Push while full without a simultaneous pop SHALL drop the new record and increment drop_count; txn_count still increments.
REQ-024 Simultaneous push and pop when full SHALL accept the push with no drop.
REQ-025 A valid mismatch SHALL only pulse err_valid; it is non-fatal and SHALL NOT alter tracking or records. It is checked in both SYNC and TRACK.
REQ-026 Record outputs SHALL be zero whenever rec_valid=0.

Reset
REQ-027 While rst=1 at a posedge, the block SHALL enter the following reset values:
  - mode SYNC, prev_state IDLE, counter 0, sat 0;
  - FIFO empty, rec_valid 0, all record outputs 0;
  - err_order 0, err_valid 0;
  - txn_count 0, drop_count 0.
REQ-028 Reset mid-transaction SHALL discard the partial transaction and all buffered records with no error pulse. The first IDLE sampled after release returns the FSM to TRACK.

Verification
REQ-029 Reset and rec_ready=1; then IDLE 3, ARBI 10, ADDRESS 9, DATA 17 (valid=1), IDLE -> one record arbi=10/addr=9/data=17/sat=0, rec_valid high one cycle after the IDLE sample, txn_count=1, no errors.
REQ-030 After sync, IDLE->ARBI->DATA -> err_order one pulse, no record, FSM in SYNC; next clean transaction is recorded normally and txn_count=1.
REQ-031 valid_in=1 for 2 cycles during ADDRESS -> err_valid high exactly 2 cycles, record still produced with correct lengths.
REQ-032 rec_ready=0, three clean transactions -> first two buffered, third dropped, drop_count=1, txn_count=3; raise rec_ready -> records 1 then 2 popped in order, then rec_valid=0.
REQ-033 CNT_W=8, ARBI held 300 cycles -> arbi_len=255, rec_sat=1; the next transaction has rec_sat=0.
REQ-034 rst pulsed during DATA with one record buffered -> rec_valid=0 and both counts 0 next cycle; DATA->IDLE after release produces no record and no err_order.
